hilo_unit: RTL and testbench

HILO_UNIT -- requirements
Module: hilo_unit

---
 rtl/hilo_unit.sv | 95 +++++++++
 tb/tb_hilo_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
// hilo_unit : HI/LO multiply-result register pair; MULT/MTHI/MTLO loads, plus
//             MADD/MSUB accumulate when built with HILO_MADD_EN defined.
// Rev 1.0
// ============================================================================
module hilo_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        OpValid,
  input  logic [2:0]  Op,
  input  logic [63:0] Product,
  input  logic [31:0] RsData,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        HiLoZero
);

  localparam logic [2:0] c_op_mult = 3'b001;
  localparam logic [2:0] c_op_mthi = 3'b010;
  localparam logic [2:0] c_op_mtlo = 3'b011;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        w_idle;
  logic        w_accum;
  logic        w_accept;
  logic [63:0] w_acc_sum;

`ifdef HILO_MADD_EN
  localparam logic [2:0] c_op_madd = 3'b100;
  localparam logic [2:0] c_op_msub = 3'b101;
  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_accum = 1'b1;

  logic [0:0]  r_state;
  logic [63:0] r_capt;
  logic        r_sub;
  logic        w_start;

  assign w_idle  = (r_state == c_st_idle);
  assign w_accum = (r_state == c_st_accum);
  assign w_start = w_accept && ((Op == c_op_madd) || (Op == c_op_msub));

  // Sum is formed from the captured operand only, so a new request held
  // on the inputs during ACCUM has no effect.
  assign w_acc_sum = r_sub ? ({r_hi, r_lo} - r_capt) : ({r_hi, r_lo} + r_capt);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= c_st_idle;
      r_capt  <= 64'h0;
      r_sub   <= 1'b0;
    end else if (w_start) begin
      r_state <= c_st_accum;
      r_capt  <= Product;
      r_sub   <= (Op == c_op_msub);
    end else begin
      r_state <= c_st_idle;
    end
  end

  assign Busy = w_accum;
`else
  assign w_idle    = 1'b1;
  assign w_accum   = 1'b0;
  assign w_acc_sum = 64'h0;
  assign Busy      = 1'b0;
`endif

  assign w_accept = OpValid && w_idle;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_hi <= 32'h0;
      r_lo <= 32'h0;
    end else if (w_accum) begin
      {r_hi, r_lo} <= w_acc_sum;
    end else if (w_accept) begin
      case (Op)
        c_op_mult: {r_hi, r_lo} <= Product;
        c_op_mthi: r_hi <= RsData;
        c_op_mtlo: r_lo <= RsData;
        default: ;
      endcase
    end
  end

  assign HI       = r_hi;
  assign LO       = r_lo;
  assign HiLoZero = ({r_hi, r_lo} == 64'h0);

endmodule
`default_nettype wire

// File: tb/tb_hilo_unit.sv
`default_nettype none
// ============================================================================
// tb_hilo_unit : directed + random self-checking bench for hilo_unit.
// Rev 1.0
// ============================================================================
module tb_hilo_unit;

  logic        Clk;
  logic        Reset;
  logic        OpValid;
  logic [2:0]  Op;
  logic [63:0] Product;
  logic [31:0] RsData;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;
  logic        HiLoZero;

  int errors;
  int checks;

  // Reference model: the architectural 64-bit HI:LO value plus a queue of
  // accumulates that have been accepted but not yet applied ({sub, operand}).
  logic [63:0] m_hilo;
  logic [64:0] m_pend[$];

  hilo_unit dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .OpValid  (OpValid),
    .Op       (Op),
    .Product  (Product),
    .RsData   (RsData),
    .HI       (HI),
    .LO       (LO),
    .Busy     (Busy),
    .HiLoZero (HiLoZero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_hi"},   {32'h0, HI},       {32'h0, m_hilo[63:32]});
    chk({tag, "_lo"},   {32'h0, LO},       {32'h0, m_hilo[31:0]});
    chk({tag, "_busy"}, {63'h0, Busy},     {63'h0, (m_pend.size() != 0)});
    chk({tag, "_zero"}, {63'h0, HiLoZero}, {63'h0, (m_hilo == 64'h0)});
  endtask

  // Rules applied once per rising edge with the request presented that cycle.
  task automatic model_edge(input logic v, input logic [2:0] op,
                            input logic [63:0] p, input logic [31:0] rs);
    logic [64:0] e;
    if (m_pend.size() != 0) begin
      e = m_pend.pop_front();
      m_hilo = e[64] ? (m_hilo - e[63:0]) : (m_hilo + e[63:0]);
    end else if (v) begin
      case (op)
        3'd1: m_hilo = p;
        3'd2: m_hilo[63:32] = rs;
        3'd3: m_hilo[31:0] = rs;
`ifdef HILO_MADD_EN
        3'd4: m_pend.push_back({1'b0, p});
        3'd5: m_pend.push_back({1'b1, p});
`endif
        default: ;
      endcase
    end
  endtask

  // Called at a falling edge: check current outputs, drive, run one edge.
  task automatic step(input string tag, input logic v, input logic [2:0] op,
                      input logic [63:0] p, input logic [31:0] rs);
    chk_model(tag);
    OpValid = v;
    Op      = op;
    Product = p;
    RsData  = rs;
    @(posedge Clk);
    model_edge(v, op, p, rs);
    @(negedge Clk);
  endtask

  task automatic pulse_reset(input string tag);
    Reset = 1'b1;
    #1;
    m_hilo = 64'h0;
    m_pend.delete();
    chk_model(tag);
    chk({tag, "_hi0"}, {32'h0, HI}, 64'h0);
    chk({tag, "_zero1"}, {63'h0, HiLoZero}, 64'h1);
    chk({tag, "_busy0"}, {63'h0, Busy}, 64'h0);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    Clk     = 1'b0;
    Reset   = 1'b1;
    OpValid = 1'b0;
    Op      = 3'd0;
    Product = 64'h0;
    RsData  = 32'h0;
    m_hilo  = 64'h0;
    #2;
    chk_model("reset");
    @(negedge Clk);
    Reset = 1'b0;

    // MULT on the first edge after reset release
    step("mult", 1'b1, 3'd1, 64'h0000_0001_FFFF_FFFE, 32'h0);
    chk("mult_hi", {32'h0, HI}, 64'h1);
    chk("mult_lo", {32'h0, LO}, 64'hFFFF_FFFE);
    chk("mult_zero", {63'h0, HiLoZero}, 64'h0);

    step("mthi", 1'b1, 3'd2, 64'h1234, 32'hDEAD_BEEF);
    step("mtlo", 1'b1, 3'd3, 64'h5678, 32'h0000_0010);
    chk("mtx_hi", {32'h0, HI}, 64'hDEAD_BEEF);
    chk("mtx_lo", {32'h0, LO}, 64'h0000_0010);

    // No-effect requests
    step("novalid", 1'b0, 3'd1, 64'hAAAA_BBBB_CCCC_DDDD, 32'h1111);
    step("nop",     1'b1, 3'd0, 64'hAAAA_BBBB_CCCC_DDDD, 32'h2222);
    step("rsv6",    1'b1, 3'd6, 64'hAAAA_BBBB_CCCC_DDDD, 32'h3333);
    step("rsv7",    1'b1, 3'd7, 64'hAAAA_BBBB_CCCC_DDDD, 32'h4444);
    chk("hold_hi", {32'h0, HI}, 64'hDEAD_BEEF);

    pulse_reset("midrst");

    // MADD wrap
    step("madd_set", 1'b1, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0);
    step("madd", 1'b1, 3'd4, 64'h2, 32'h0);
`ifdef HILO_MADD_EN
    chk("madd_busy", {63'h0, Busy}, 64'h1);
    step("madd_acc", 1'b0, 3'd0, 64'h0, 32'h0);
    chk("madd_res", {HI, LO}, 64'h1);
`else
    chk("madd_busy", {63'h0, Busy}, 64'h0);
    chk("madd_res", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

    // MSUB borrow with a MULT held while Busy
    step("msub_set", 1'b1, 3'd1, 64'h0, 32'h0);
    step("msub", 1'b1, 3'd5, 64'h1, 32'h0);
    step("msub_held", 1'b1, 3'd1, 64'h0123_4567_89AB_CDEF, 32'h0);
`ifdef HILO_MADD_EN
    chk("msub_res", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("msub_busy", {63'h0, Busy}, 64'h0);
`else
    chk("msub_res", {HI, LO}, 64'h0123_4567_89AB_CDEF);
`endif
    step("msub_mult", 1'b1, 3'd1, 64'h0123_4567_89AB_CDEF, 32'h0);
    chk("msub_mult_res", {HI, LO}, 64'h0123_4567_89AB_CDEF);

    // Reset during the ACCUM cycle
    step("rstacc_set", 1'b1, 3'd1, 64'h5, 32'h0);
    step("rstacc_madd", 1'b1, 3'd4, 64'h7, 32'h0);
    chk_model("rstacc_pre");
    pulse_reset("rstacc");
    step("rstacc_after", 1'b0, 3'd0, 64'h0, 32'h0);
    chk("rstacc_res", {HI, LO}, 64'h0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)),
           {32'($urandom), 32'($urandom)}, 32'($urandom));
    end
    chk_model("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
